// File: rtl/lsu_mem_ctrl_if.sv
// lsu_mem_ctrl_if: bundles the core-side request/response handshake and the
// request/grant/response data-memory port of the load/store unit.
//   master : the load/store unit (answers the core, drives the memory port)
//   slave  : its environment (the core pipeline plus the data memory)
interface lsu_mem_ctrl_if;
    // core side
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_memop;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    // memory side
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        input  req_valid, req_we, req_memop, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        output req_valid, req_we, req_memop, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: multi-cycle load/store unit. Accepts one decoded memory
// operation at a time, drives a request/grant/response memory port with byte
// enables and lane-replicated store data, and returns sign/zero-extended load
// data with a one-cycle completion pulse. busy stalls the core while active.
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- when defined, misaligned
// half/word accesses complete immediately with resp_err=1 and never reach
// memory; when undefined the unused low address bits are simply ignored.
module lsu_mem_ctrl (
    input  logic           clk,
    input  logic           rst_n,
    lsu_mem_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Byte enables for the access size at the given byte offset.
    function automatic logic [3:0] byte_en(input logic [2:0] memop, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (memop[1:0])
            2'b01:   be = 4'b0001 << addr_lo;
            2'b10:   be = 4'b0011 << {addr_lo[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the store operand across every lane it could land in.
    function automatic logic [31:0] store_data(input logic [2:0] memop, input logic [31:0] wdata);
        logic [31:0] res;
        case (memop[1:0])
            2'b01:   res = {4{wdata[7:0]}};
            2'b10:   res = {2{wdata[15:0]}};
            default: res = wdata;
        endcase
        return res;
    endfunction

    // Pick the addressed lane out of the read word and extend it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [2:0] memop, input logic [1:0] addr_lo,
                                                input logic [31:0] rdata);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res;
        case (addr_lo)
            2'b00:   byte_v = rdata[7:0];
            2'b01:   byte_v = rdata[15:8];
            2'b10:   byte_v = rdata[23:16];
            2'b11:   byte_v = rdata[31:24];
            default: byte_v = rdata[7:0];
        endcase
        if (addr_lo[1]) begin
            half_v = rdata[31:16];
        end else begin
            half_v = rdata[15:0];
        end
        case (memop[1:0])
            2'b01:   res = memop[2] ? {24'h000000, byte_v} : {{24{byte_v[7]}}, byte_v};
            2'b10:   res = memop[2] ? {16'h0000, half_v} : {{16{half_v[15]}}, half_v};
            default: res = rdata;
        endcase
        return res;
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    // A half access must be 2-byte aligned, a word access 4-byte aligned.
    function automatic logic is_misaligned(input logic [2:0] memop, input logic [1:0] addr_lo);
        logic mis;
        case (memop[1:0])
            2'b01:   mis = 1'b0;
            2'b10:   mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction
`endif

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  memop_q, memop_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic        resp_valid_q, resp_valid_d;
    logic        trap_s;

    // Flag an incoming request that must complete as a misaligned trap.
    always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
        trap_s = is_misaligned(bus.req_memop, bus.req_addr[1:0]);
`else
        trap_s = 1'b0;
`endif
    end

    // Next-state logic; outputs are precomputed from the next state so they leave flops.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        memop_d     = memop_q;
        addr_lo_d   = addr_lo_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    we_d        = bus.req_we;
                    memop_d     = bus.req_memop;
                    addr_lo_d   = bus.req_addr[1:0];
                    mem_addr_d  = {bus.req_addr[31:2], 2'b00};
                    mem_be_d    = byte_en(bus.req_memop, bus.req_addr[1:0]);
                    mem_wdata_d = store_data(bus.req_memop, bus.req_wdata);
                    rdata_d     = 32'h0000_0000;
                    err_d       = trap_s;
                    if (trap_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_REQ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.mem_gnt) begin
                    if (we_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (bus.mem_rvalid) begin
                    rdata_d = load_extend(memop_q, addr_lo_q, bus.mem_rdata);
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d      = (state_d == ST_IDLE);
        busy_d       = (state_d != ST_IDLE);
        mem_req_d    = (state_d == ST_REQ);
        mem_we_d     = (state_d == ST_REQ) && we_d;
        resp_valid_d = (state_d == ST_DONE);
    end

    // State, latched request and registered outputs; reset aborts any access at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            memop_q      <= 3'b000;
            addr_lo_q    <= 2'b00;
            mem_addr_q   <= 32'h0000_0000;
            mem_be_q     <= 4'b0000;
            mem_wdata_q  <= 32'h0000_0000;
            rdata_q      <= 32'h0000_0000;
            err_q        <= 1'b0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            memop_q      <= memop_d;
            addr_lo_q    <= addr_lo_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.busy       = busy_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_be     = mem_be_q;
    assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed vectors for lsu_mem_ctrl. The stimulus process
// pushes expected memory-port requests and expected responses into queues;
// a negedge monitor (which also plays the data memory) pops and compares.
// Build with or without LSU_MISALIGN_TRAP_EN; expectations follow the macro.
module tb_lsu_mem_ctrl;

    logic clk;
    logic rst_n;

    lsu_mem_ctrl_if bus_if ();

    lsu_mem_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rd;
        int          gd;
        int          rvd;
    } bus_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          lat;
    } resp_t;

    typedef struct {
        string       nm;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    bus_t        bus_q[$];
    resp_t       resp_q[$];
    chk_t        chk_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          abort_cnt = 0;
    int          abort_seen = 0;
    int          inject_cnt = 0;
    int          inject_seen = 0;
    int          req_cnt = 0;
    int          rv_wait = -1;
    logic [31:0] cur_rd = 32'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic post(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_t c;
        c.nm = nm;
        c.act = act;
        c.exp = exp;
        chk_q.push_back(c);
    endtask

    // Monitor and memory model, evaluated on the falling edge.
    always @(negedge clk) begin
        chk_t  c;
        resp_t r;
        bus_t  b;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            cmp(c.nm, c.act, c.exp);
        end
        if (bus_if.resp_valid === 1'b1) begin
            if (resp_q.size() == 0) begin
                cmp("resp_unexpected", {31'd0, bus_if.resp_valid}, 32'd0);
            end else begin
                r = resp_q.pop_front();
                cmp("resp_rdata", bus_if.resp_rdata, r.rdata);
                cmp("resp_err", {31'd0, bus_if.resp_err}, {31'd0, r.err});
                cmp("resp_latency", cyc - r.acc, r.lat);
            end
        end
        bus_if.mem_gnt    = 1'b0;
        bus_if.mem_rvalid = 1'b0;
        if (abort_cnt != abort_seen) begin
            abort_seen = abort_cnt;
            rv_wait = -1;
        end
        if (inject_cnt != inject_seen) begin
            inject_seen = inject_cnt;
            bus_if.mem_rvalid = 1'b1;
            bus_if.mem_rdata  = 32'hFFFF_FFFF;
        end else if (rv_wait == 0) begin
            bus_if.mem_rvalid = 1'b1;
            bus_if.mem_rdata  = cur_rd;
            rv_wait = -1;
        end else if (rv_wait > 0) begin
            rv_wait = rv_wait - 1;
        end
        if (bus_if.mem_req === 1'b1) begin
            if (bus_q.size() == 0) begin
                cmp("mem_req_unexpected", {31'd0, bus_if.mem_req}, 32'd0);
            end else begin
                b = bus_q[0];
                cmp("mem_addr", bus_if.mem_addr, b.addr);
                cmp("mem_be", {28'd0, bus_if.mem_be}, {28'd0, b.be});
                cmp("mem_we", {31'd0, bus_if.mem_we}, {31'd0, b.we});
                if (b.we) cmp("mem_wdata", bus_if.mem_wdata, b.wdata);
                if (req_cnt >= b.gd) begin
                    bus_if.mem_gnt = 1'b1;
                    req_cnt = 0;
                    void'(bus_q.pop_front());
                    if (!b.we) begin
                        rv_wait = b.rvd;
                        cur_rd  = b.rd;
                    end
                end else begin
                    req_cnt++;
                end
            end
        end else begin
            req_cnt = 0;
        end
    end

    // One request, presented for exactly one cycle while the unit is idle.
    task automatic issue(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd, input int gd, input int rvd,
                         input logic [3:0] exp_be, input logic [31:0] exp_wd,
                         input logic [31:0] exp_rd, input logic exp_err, input int lat,
                         input bit to_bus, input bit want_resp);
        bus_t  b;
        resp_t r;
        @(negedge clk);
        bus_if.req_valid = 1'b1;
        bus_if.req_we    = we;
        bus_if.req_memop = op;
        bus_if.req_addr  = addr;
        bus_if.req_wdata = wd;
        if (to_bus) begin
            b.addr = {addr[31:2], 2'b00};
            b.be = exp_be;
            b.we = we;
            b.wdata = exp_wd;
            b.rd = rd;
            b.gd = gd;
            b.rvd = rvd;
            bus_q.push_back(b);
        end
        if (want_resp) begin
            r.rdata = exp_rd;
            r.err = exp_err;
            r.acc = cyc;
            r.lat = lat;
            resp_q.push_back(r);
        end
        @(negedge clk);
        bus_if.req_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((resp_q.size() + bus_q.size()) != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        post(nm, resp_q.size() + bus_q.size(), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        resp_t r;
        bus_t  b;
        rst_n            = 1'b0;
        bus_if.req_valid = 1'b0;
        bus_if.req_we    = 1'b0;
        bus_if.req_memop = 3'b000;
        bus_if.req_addr  = 32'h0;
        bus_if.req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        post("rst_req_ready", {31'd0, bus_if.req_ready}, 32'd1);
        post("rst_busy", {31'd0, bus_if.busy}, 32'd0);
        post("rst_resp_valid", {31'd0, bus_if.resp_valid}, 32'd0);
        post("rst_resp_err", {31'd0, bus_if.resp_err}, 32'd0);
        post("rst_resp_rdata", bus_if.resp_rdata, 32'd0);
        post("rst_mem_req", {31'd0, bus_if.mem_req}, 32'd0);
        post("rst_mem_we", {31'd0, bus_if.mem_we}, 32'd0);
        post("rst_mem_addr", bus_if.mem_addr, 32'd0);
        post("rst_mem_be", {28'd0, bus_if.mem_be}, 32'd0);
        post("rst_mem_wdata", bus_if.mem_wdata, 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // we op addr wdata rdata gd rvd | be wdata rdata err lat | bus resp
        issue(1'b0, 3'b001, 32'h103, 32'h0, 32'h80FF_1234, 0, 0, 4'b1000, 32'h0, 32'hFFFF_FF80, 1'b0, 3, 1'b1, 1'b1);
        drain("d_lb_103");
        issue(1'b0, 3'b110, 32'h102, 32'h0, 32'h9ABC_0000, 0, 0, 4'b1100, 32'h0, 32'h0000_9ABC, 1'b0, 3, 1'b1, 1'b1);
        drain("d_lhu_102");
        issue(1'b0, 3'b010, 32'h102, 32'h0, 32'h9ABC_0000, 0, 0, 4'b1100, 32'h0, 32'hFFFF_9ABC, 1'b0, 3, 1'b1, 1'b1);
        drain("d_lh_102");
        issue(1'b1, 3'b001, 32'h41, 32'h1234_56AB, 32'h0, 2, 0, 4'b0010, 32'hABAB_ABAB, 32'h0, 1'b0, 4, 1'b1, 1'b1);
        drain("d_sb_41");
`ifdef LSU_MISALIGN_TRAP_EN
        issue(1'b0, 3'b000, 32'h42, 32'h0, 32'h0, 0, 0, 4'b1111, 32'h0, 32'h0, 1'b1, 1, 1'b0, 1'b1);
        drain("d_lw_42_trap");
        issue(1'b0, 3'b010, 32'h103, 32'h0, 32'h0, 0, 0, 4'b1100, 32'h0, 32'h0, 1'b1, 1, 1'b0, 1'b1);
        drain("d_lh_103_trap");
`else
        issue(1'b0, 3'b000, 32'h42, 32'h0, 32'hDEAD_BEEF, 0, 0, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 1'b1, 1'b1);
        drain("d_lw_42");
        issue(1'b0, 3'b010, 32'h103, 32'h0, 32'h7FFF_0000, 0, 0, 4'b1100, 32'h0, 32'h0000_7FFF, 1'b0, 3, 1'b1, 1'b1);
        drain("d_lh_103");
`endif
        issue(1'b1, 3'b110, 32'h46, 32'h0000_CAFE, 32'h0, 0, 0, 4'b1100, 32'hCAFE_CAFE, 32'h0, 1'b0, 2, 1'b1, 1'b1);
        drain("d_sh_46");
        issue(1'b0, 3'b101, 32'h201, 32'h0, 32'h1234_F600, 0, 0, 4'b0010, 32'h0, 32'h0000_00F6, 1'b0, 3, 1'b1, 1'b1);
        drain("d_lbu_201");
        issue(1'b1, 3'b000, 32'h80, 32'h0102_0304, 32'h0, 1, 0, 4'b1111, 32'h0102_0304, 32'h0, 1'b0, 3, 1'b1, 1'b1);
        drain("d_sw_80");
        issue(1'b0, 3'b000, 32'h300, 32'h0, 32'h55AA_00FF, 0, 2, 4'b1111, 32'h0, 32'h55AA_00FF, 1'b0, 5, 1'b1, 1'b1);
        drain("d_lw_300_slow");
        issue(1'b1, 3'b011, 32'h10, 32'hA5A5_5A5A, 32'h0, 0, 0, 4'b1111, 32'hA5A5_5A5A, 32'h0, 1'b0, 2, 1'b1, 1'b1);
        drain("d_sw_op3");
        issue(1'b0, 3'b001, 32'h100, 32'h0, 32'h0000_007F, 0, 0, 4'b0001, 32'h0, 32'h0000_007F, 1'b0, 3, 1'b1, 1'b1);
        drain("d_lb_pos");
        issue(1'b0, 3'b010, 32'h200, 32'h0, 32'h0000_8001, 0, 0, 4'b0011, 32'h0, 32'hFFFF_8001, 1'b0, 3, 1'b1, 1'b1);
        drain("d_lh_lo");

        // reset while a store waits for grant
        issue(1'b1, 3'b000, 32'h50, 32'h1122_3344, 32'h0, 1000, 0, 4'b1111, 32'h1122_3344, 32'h0, 1'b0, 0, 1'b1, 1'b0);
        @(negedge clk);
        post("pre_rst_mem_req", {31'd0, bus_if.mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        post("rstreq_mem_req", {31'd0, bus_if.mem_req}, 32'd0);
        post("rstreq_busy", {31'd0, bus_if.busy}, 32'd0);
        post("rstreq_ready", {31'd0, bus_if.req_ready}, 32'd1);
        bus_q.delete();
        abort_cnt++;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // reset while a load waits for data; the late data must be ignored
        issue(1'b0, 3'b000, 32'h60, 32'h0, 32'h1234_5678, 0, 1000, 4'b1111, 32'h0, 32'h0, 1'b0, 0, 1'b1, 1'b0);
        @(negedge clk);
        post("pre_rst_busy", {31'd0, bus_if.busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        post("rstwait_busy", {31'd0, bus_if.busy}, 32'd0);
        post("rstwait_mem_req", {31'd0, bus_if.mem_req}, 32'd0);
        abort_cnt++;
        @(negedge clk);
        #2 rst_n = 1'b1;
        inject_cnt++;
        repeat (5) @(negedge clk);
        post("post_rst_busy", {31'd0, bus_if.busy}, 32'd0);
        post("post_rst_resp", {31'd0, bus_if.resp_valid}, 32'd0);

        // req_valid held high for 12 cycles: stores accepted at cycles 0,3,6,9
        @(negedge clk);
        bus_if.req_valid = 1'b1;
        bus_if.req_we    = 1'b1;
        bus_if.req_memop = 3'b001;
        bus_if.req_addr  = 32'h20;
        bus_if.req_wdata = 32'h0000_0077;
        for (int k = 0; k < 4; k++) begin
            b.addr = 32'h20;
            b.be = 4'b0001;
            b.we = 1'b1;
            b.wdata = 32'h7777_7777;
            b.rd = 32'h0;
            b.gd = 0;
            b.rvd = 0;
            bus_q.push_back(b);
            r.rdata = 32'h0;
            r.err = 1'b0;
            r.acc = cyc + 3 * k;
            r.lat = 2;
            resp_q.push_back(r);
        end
        repeat (12) @(negedge clk);
        bus_if.req_valid = 1'b0;
        drain("d_b2b");
        repeat (4) @(negedge clk);
        post("final_queues", resp_q.size() + bus_q.size(), 32'd0);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Multi-cycle load/store unit that sits directly downstream of the control-signal decoder in the RISC-V core. Consumes the decoded memory operation (MemOp, MemWr, MemtoReg path) together with the ALU-computed address and rs2 store data. Drives a request/grant/response data-memory port, generates byte enables and lane-replicated store data, and sign/zero-extends load data. Provides a busy indication so the core can stall until the access completes.

## Interface
- No parameters; data and address are fixed at 32 bits.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: access request; sampled only in IDLE.
- `req_ready` out 1: high only in IDLE.
- `req_we` in 1: 1 = store (MemWr), 0 = load (MemtoReg).
- `req_memop` in 3: decoder MemOp. 000 word, 001 byte signed, 010 half signed, 101 byte unsigned, 110 half unsigned. 011/100/111 are treated as word.
- `req_addr` in 32: byte address from the ALU.
- `req_wdata` in 32: store data (rs2).
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data, valid with `resp_valid`. Zero for stores.
- `resp_err` out 1: misaligned-access flag, valid with `resp_valid`.
- `busy` out 1: state ≠ IDLE; used as the core stall.
- `mem_req` out 1: memory request, high throughout REQ.
- `mem_we` out 1: memory write.
- `mem_addr` out 32: `{addr[31:2],2'b00}`.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_gnt` in 1: memory accepts the request this cycle.
- `mem_rvalid` in 1: load data returned.
- `mem_rdata` in 32: aligned read word.

## Operation
- States: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- **IDLE**
  - When `req_valid` is high, latch we/memop/addr/wdata.
  - If the access is misaligned and the misalign trap is compiled in (see Configuration), go to DONE with err=1.
  - Otherwise go to REQ.
- **REQ**
  - `mem_req`=1. `mem_we`, `mem_addr`, `mem_be`, `mem_wdata` are driven from the latched request and held stable until grant.
  - On `mem_gnt`: a store goes to DONE; a load goes to WAIT.
- **WAIT**
  - `mem_req`=0.
  - On `mem_rvalid`, capture the extended data into `resp_rdata` and go to DONE.
  - `mem_rvalid` outside WAIT is ignored.
- **DONE**: `resp_valid`=1 for exactly one cycle, then IDLE.
- Byte enables:
  - byte: `4'b0001 << addr[1:0]`
  - half: `4'b0011 << {addr[1],1'b0}`
  - word: `4'b1111`
- Store data:
  - byte: `{4{wdata[7:0]}}`
  - half: `{2{wdata[15:0]}}`
  - word: unchanged.
- Load extraction:
  - Select the byte lane by `addr[1:0]`, or the half lane by `addr[1]`.
  - Sign-extend when `memop[2]`=0; zero-extend when `memop[2]`=1.
- Misaligned: a half access with `addr[0]`=1, or a word access with `addr[1:0]`≠0.

## Timing
- Reset values: `req_ready`=1; every other output is 0; `resp_rdata`=0.
- Reset asserted mid-access returns to IDLE immediately and drops `mem_req` asynchronously. A pending memory response is then ignored.
- Zero-wait memory (gnt in the first REQ cycle, rvalid one cycle later), with the request accepted at cycle 0:
  - load: REQ at cycle 1, WAIT at cycle 2, `resp_valid` at cycle 3.
  - store: `resp_valid` at cycle 2.
- Trapped misaligned access: `resp_valid`+`resp_err` at cycle 1; no `mem_req` is issued.
- Each cycle without `mem_gnt` in REQ, or without `mem_rvalid` in WAIT, adds one cycle of latency. There is no timeout.
- Memory must not assert `mem_rvalid` in the same cycle as `mem_gnt`.
- `busy` is high from the cycle after acceptance through DONE inclusive.
- Only one access is outstanding at a time. `req_valid` outside IDLE is ignored.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- **Defined**
  - A misaligned access completes with `resp_err`=1.
  - No memory transaction is issued and `resp_rdata`=0.
- **Undefined**
  - `resp_err` is tied 0.
  - Unused low address bits are ignored: a half access uses `addr[1]` only; a word access ignores `addr[1:0]`.
  - The access proceeds normally.

## Test plan
- Zero-wait load, memop=001, addr=0x103, `mem_rdata`=0x80FF1234 → `mem_be`=1000, `resp_rdata`=0xFFFFFF80, `resp_valid` at cycle 3.
- Load, memop=110, addr=0x102, `mem_rdata`=0x9ABC0000 → `resp_rdata`=0x00009ABC. Same access with memop=010 → 0xFFFF9ABC.
- Store, memop=001, addr=0x41, wdata=0x123456AB, `mem_gnt` delayed 2 cycles → `mem_be`=0010 and `mem_wdata`=0xABABABAB held stable, `resp_valid` at cycle 4.
- Word load at addr=0x42:
  - with `LSU_MISALIGN_TRAP_EN` → `resp_err`=1 at cycle 1 and `mem_req` never asserted.
  - without → `mem_addr`=0x40, `mem_be`=1111, `resp_err`=0.
- `rst_n` low while in WAIT → `busy`=0 and `mem_req`=0 at once. A later `mem_rvalid` produces no `resp_valid`.
- `req_valid` held high continuously → back-to-back accesses accepted only in IDLE, with exactly one `resp_valid` per accepted request.
